spi_gopigo_cmd_responder: RTL
=============================

// Module: spi_gopigo_cmd_responder
// PURPOSE
//  SPI slave (responder) for the robot command link: the receiving end of the FPGA SPI master that
//  streams motor PWM and LED colours. Samples SCLK/MOSI/SS_N in the system clock domain and decodes
//  addressed command frames into held output registers. Echoes received bytes on MISO.
//  Used as the board-side model in loopback benches and as a peripheral on secondary FPGA boards.
// PARAMETERS
//  DEV_ADDR     8'h08  frame address byte this responder accepts
//  SYNC_STAGES  2      synchroniser flops on sclk_i, mosi_i, spi_ss_n_i (>=2)
// PORTS
//  clk                  in   1   system clock; all logic on rising edge
//  rst                  in   1   synchronous, active-high reset
//  sclk_i               in   1   SPI clock, mode 0 (CPOL=0, CPHA=0), async to clk; f_sclk <= f_clk/8
//  mosi_i               in   1   SPI data from master, MSB first
//  spi_ss_n_i           in   1   slave select, active low; frame = one low period
//  miso_o               out  1   SPI data to master
//  miso_en_o            out  1   1 while synced ss_n low (tri-state enable)
//  rpi_running_i        in   1   master-alive flag; 0 forces motor outputs to 0
//  motor_pwm_left_o     out  8   two's complement, -100..100 (not clamped)
//  motor_pwm_rght_o     out  8   two's complement
//  led_eye_left_rgb_o   out  24  R[23:16] G[15:8] B[7:0]
//  led_eye_rght_rgb_o   out  24  same format
//  led_blink_left_rgb_o out  24  same format
//  led_blink_rght_rgb_o out  24  same format
//  upd_o                out  1   1-cycle pulse when a frame is committed
//  upd_cmd_o            out  3   command index of last committed frame (valid with upd_o, held)
//  frame_err_o          out  1   1-cycle pulse when a frame is discarded
// BEHAVIOUR
//  Reset: all outputs 0, miso_o 0, miso_en_o 0, FSM IDLE, shift regs and byte counter cleared.
//  Inputs pass through SYNC_STAGES flops; edges detected on synced signals (prev vs current).
//  Frame: byte0 = address, byte1 = command, then payload. Commands (len = payload bytes):
//   0x01 MOTOR_PWM_LEFT len1 | 0x02 MOTOR_PWM_RGHT len1 | 0x03 LED_EYE_LEFT len3
//   0x04 LED_EYE_RGHT len3   | 0x05 LED_BLINK_LEFT len3 | 0x06 LED_BLINK_RGHT len3 (R,G,B order)
//  RX: bit sampled on synced sclk rising edge into rx_sr, MSB first; 8th edge completes a byte.
//  FSM: IDLE -(ss_n fall)-> ADDR; ADDR -(byte==DEV_ADDR)-> CMD, else IGNORE;
//   CMD -(valid cmd)-> DATA (payload counter = len), else IGNORE;
//   DATA: store bytes in staging regs, count down; extra bytes beyond len -> IGNORE;
//   any state -(ss_n rise)-> IDLE.
//  Commit: on ss_n rise, if state DATA and all len bytes received with no partial bit count,
//   copy staging into target output on the next clk; upd_o=1 and upd_cmd_o=cmd that cycle.
//  Discard (frame_err_o pulse on the cycle after ss_n rise): wrong address, unknown command,
//   short payload, extra bytes, or ss_n rise with 1..7 bits of a byte pending.
//   Outputs unchanged on discard. ss_n rise in IDLE (glitch, no bits) -> no pulse.
//  Outputs change only at commit; staging is never visible. Other outputs hold their values.
//  TX: tx_sr loaded with 0x00 on ss_n fall; on the synced sclk falling edge after a completed
//   byte, tx_sr <= that received byte; other falling edges shift tx_sr left; miso_o = tx_sr[7].
//   So byte k (k>=1) on MISO echoes byte k-1 on MOSI; byte0 returns 0x00.
//  rpi_running_i=0: motor_pwm_*_o read 0 combinationally-masked-free (registered, 1-cycle lag);
//   stored motor values kept and reappear when rpi_running_i returns 1. LEDs unaffected.
//  sclk edges while ss_n high are ignored; bit counter resets on every ss_n fall.
//  rst mid-frame: immediate return to IDLE, all outputs 0; remainder of frame ignored until next ss_n fall.
// TESTING
//  1 frame 08 01 9C (f_sclk=f_clk/8) -> motor_pwm_left_o=8'h9C (-100), upd_o 1 pulse, upd_cmd_o=1
//  2 frame 08 06 11 22 33 -> led_blink_rght_rgb_o=24'h112233; MISO bytes 00 08 06 11 22
//  3 frame 09 01 20, then 08 07 00 -> 2 frame_err_o pulses, no output changes, no upd_o
//  4 frame 08 03 AA BB (short) and 08 02 10 10 (long) and ss_n rise after 4 bits -> frame_err_o each, outputs hold
//  5 commit 08 02 64, drop rpi_running_i -> motor_pwm_rght_o=0; raise again -> 8'h64
//  6 rst asserted after byte1 of 08 04 .. -> all outputs 0, no upd_o; next full frame commits normally

Source files
------------

// File: rtl/spi_gopigo_cmd_responder_if.sv
// SPI pins between the command-link master and the board-side responder.
interface spi_gopigo_cmd_responder_if;
  logic sclk_i;
  logic mosi_i;
  logic spi_ss_n_i;
  logic miso_o;
  logic miso_en_o;

  modport master (output sclk_i, mosi_i, spi_ss_n_i, input miso_o, miso_en_o);
  modport slave  (input sclk_i, mosi_i, spi_ss_n_i, output miso_o, miso_en_o);
endinterface

// File: rtl/spi_gopigo_cmd_responder.sv
// SPI mode-0 responder: decodes addressed command frames into held motor/LED registers, echoes MOSI on MISO.
//   state  | meaning
//   IDLE   | no frame in progress (ss_n high, or frame abandoned by reset)
//   ADDR   | receiving address byte
//   CMD    | receiving command byte
//   DATA   | receiving payload into staging, pay_cnt bytes still expected
//   IGNORE | frame rejected, wait for ss_n rise and flag it
module spi_gopigo_cmd_responder #(
  parameter logic [7:0] DEV_ADDR    = 8'h08,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_gopigo_cmd_responder_if.slave  spi,
  input  logic                       rpi_running_i,
  output logic [7:0]                 motor_pwm_left_o,
  output logic [7:0]                 motor_pwm_rght_o,
  output logic [23:0]                led_eye_left_rgb_o,
  output logic [23:0]                led_eye_rght_rgb_o,
  output logic [23:0]                led_blink_left_rgb_o,
  output logic [23:0]                led_blink_rght_rgb_o,
  output logic                       upd_o,
  output logic [2:0]                 upd_cmd_o,
  output logic                       frame_err_o
);

  typedef enum logic [2:0] {IDLE, ADDR, CMD, DATA, IGNORE} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic sclk_s, mosi_s, ss_s, sclk_prev, ss_prev, armed;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise, active;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_sr, tx_sr, byte_val;
  logic        byte_vld, byte_pend;
  logic [1:0]  pay_cnt, cmd_len;
  logic [2:0]  cmd_q;
  logic [23:0] stage;
  logic [7:0]  motor_l_q, motor_r_q, motor_l_nxt, motor_r_nxt;
  logic        commit, discard, cmd_ld, stage_shift;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];

  // Sync chains reset low, so a frame still in progress when rst drops is not seen
  // as a fresh ss_n fall; armed waits for ss_n high before frames are accepted.
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign ss_fall   = armed & ss_prev & ~ss_s;
  assign ss_rise   = ss_s & ~ss_prev;
  assign active    = ~ss_s & (state != IDLE);
  assign byte_vld  = active & sclk_rise & (bit_cnt == 3'd7);
  assign byte_val  = {rx_sr[6:0], mosi_s};

  assign spi.miso_o    = tx_sr[7];
  assign spi.miso_en_o = armed & ~ss_s;

  always_comb begin
    case (byte_val)
      8'h01, 8'h02:               cmd_len = 2'd1;
      8'h03, 8'h04, 8'h05, 8'h06: cmd_len = 2'd3;
      default:                    cmd_len = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    commit      = 1'b0;
    discard     = 1'b0;
    cmd_ld      = 1'b0;
    stage_shift = 1'b0;
    case (state)
      IDLE:   if (ss_fall) state_nxt = ADDR;
      ADDR:   if (byte_vld) state_nxt = (byte_val == DEV_ADDR) ? CMD : IGNORE;
      CMD: begin
        if (byte_vld) begin
          if (cmd_len != 2'd0) begin
            state_nxt = DATA;
            cmd_ld    = 1'b1;
          end else begin
            state_nxt = IGNORE;
          end
        end
      end
      DATA: begin
        if (byte_vld) begin
          if (pay_cnt == 2'd0) state_nxt = IGNORE;
          else                 stage_shift = 1'b1;
        end
      end
      IGNORE: state_nxt = IGNORE;
      default: state_nxt = IDLE;
    endcase
    if (ss_rise && state != IDLE) begin
      state_nxt = IDLE;
      if (state == DATA && pay_cnt == 2'd0 && bit_cnt == 3'd0) commit  = 1'b1;
      else                                                      discard = 1'b1;
    end
  end

  always_comb begin
    motor_l_nxt = motor_l_q;
    motor_r_nxt = motor_r_q;
    if (commit && cmd_q == 3'd1) motor_l_nxt = stage[7:0];
    if (commit && cmd_q == 3'd2) motor_r_nxt = stage[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync            <= '0;
      mosi_sync            <= '0;
      ss_sync              <= '0;
      sclk_prev            <= 1'b0;
      ss_prev              <= 1'b0;
      armed                <= 1'b0;
      bit_cnt              <= 3'd0;
      rx_sr                <= 8'h00;
      tx_sr                <= 8'h00;
      byte_pend            <= 1'b0;
      pay_cnt              <= 2'd0;
      cmd_q                <= 3'd0;
      stage                <= 24'h0;
      motor_l_q            <= 8'h00;
      motor_r_q            <= 8'h00;
      motor_pwm_left_o     <= 8'h00;
      motor_pwm_rght_o     <= 8'h00;
      led_eye_left_rgb_o   <= 24'h0;
      led_eye_rght_rgb_o   <= 24'h0;
      led_blink_left_rgb_o <= 24'h0;
      led_blink_rght_rgb_o <= 24'h0;
      upd_o                <= 1'b0;
      upd_cmd_o            <= 3'd0;
      frame_err_o          <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi_i};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi.spi_ss_n_i};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
      armed     <= armed | ss_s;

      if (ss_fall) begin
        bit_cnt   <= 3'd0;
        tx_sr     <= 8'h00;
        byte_pend <= 1'b0;
      end else if (active && sclk_rise) begin
        rx_sr   <= byte_val;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_pend <= 1'b1;
      end else if (active && sclk_fall) begin
        // first falling edge after a full byte loads it for echo on the next byte
        if (byte_pend) begin
          tx_sr     <= rx_sr;
          byte_pend <= 1'b0;
        end else begin
          tx_sr <= {tx_sr[6:0], 1'b0};
        end
      end

      if (cmd_ld) begin
        pay_cnt <= cmd_len;
        cmd_q   <= byte_val[2:0];
      end else if (stage_shift) begin
        pay_cnt <= pay_cnt - 2'd1;
        stage   <= {stage[15:0], byte_val};
      end

      upd_o       <= commit;
      frame_err_o <= discard;
      if (commit) begin
        upd_cmd_o <= cmd_q;
        case (cmd_q)
          3'd3:    led_eye_left_rgb_o   <= stage;
          3'd4:    led_eye_rght_rgb_o   <= stage;
          3'd5:    led_blink_left_rgb_o <= stage;
          3'd6:    led_blink_rght_rgb_o <= stage;
          default: ;
        endcase
      end

      // stored motor values survive rpi_running_i=0 and reappear when it returns
      motor_l_q        <= motor_l_nxt;
      motor_r_q        <= motor_r_nxt;
      motor_pwm_left_o <= rpi_running_i ? motor_l_nxt : 8'h00;
      motor_pwm_rght_o <= rpi_running_i ? motor_r_nxt : 8'h00;
    end
  end

endmodule
